// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared constants and FSM encoding for the camera config sequencer
package cam_cfg_pkg;
    localparam int ROM_DEPTH = 1024;
    localparam int ROM_AW = $clog2(ROM_DEPTH);
    localparam logic [7:0] END_DATA = 8'hFF;
    localparam logic [7:0] DELAY_DATA = 8'hF0;
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, SEND, WAIT_ACK, DELAY, NEXT, DONE} state_t;
endpackage

// File: rtl/cam_config_sequencer_if.sv
// cam_config_sequencer_if: config ROM read port plus SCCB command handshake
interface cam_config_sequencer_if #(parameter int I2C_ADDR_16 = 0);
    import cam_cfg_pkg::*;
    localparam int REG_W = 8 + 8 * I2C_ADDR_16;
    logic [ROM_AW-1:0] rom_addr;
    logic [REG_W+7:0] rom_dout;
    logic cmd_valid;
    logic cmd_ready;
    logic [REG_W-1:0] cmd_reg_addr;
    logic [7:0] cmd_data;
    logic cmd_done;
    logic cmd_nack;
    modport master(
        output rom_addr, cmd_valid, cmd_reg_addr, cmd_data,
        input rom_dout, cmd_ready, cmd_done, cmd_nack
    );
    modport slave(
        input rom_addr, cmd_valid, cmd_reg_addr, cmd_data,
        output rom_dout, cmd_ready, cmd_done, cmd_nack
    );
endinterface

// File: rtl/cam_cfg_delay_timer.sv
// cam_cfg_delay_timer: loadable down-counter; expired marks the last cycle of the delay
module cam_cfg_delay_timer #(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(CYCLES + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? W'(CYCLES) : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign expired = cnt_q == W'(1);
endmodule

// File: rtl/cam_config_sequencer.sv
// cam_config_sequencer: walks the config ROM and issues one SCCB write per entry.
// Define CAM_CFG_NACK_RETRY_EN to resend NACKed entries up to MAX_RETRY times.
module cam_config_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int I2C_ADDR_16 = 0,
    parameter int DELAY_CYCLES = 500000,
    parameter int MAX_RETRY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    cam_config_sequencer_if.master bus,
    output logic busy,
    output logic done,
    output logic nack_seen
);
    localparam int REG_W = 8 + 8 * I2C_ADDR_16;
`ifdef CAM_CFG_NACK_RETRY_EN
    localparam int RETRIES = MAX_RETRY;
`else
    localparam int RETRIES = 0;
`endif
    localparam int RW = $clog2(RETRIES + 2);

    state_t state_q, state_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic [REG_W-1:0] reg_q, reg_d;
    logic [7:0] data_q, data_d;
    logic nack_q, nack_d;
    logic [RW-1:0] retry_q, retry_d;
    logic load, expired;
    logic [REG_W-1:0] rom_reg;
    logic [7:0] rom_data;
    logic is_ctrl;

    assign rom_reg = bus.rom_dout[REG_W+7:8];
    assign rom_data = bus.rom_dout[7:0];
    assign is_ctrl = &rom_reg;

    cam_cfg_delay_timer #(.CYCLES(DELAY_CYCLES)) u_timer (
        .clk(clk), .rst(rst), .load(load), .en(state_q == DELAY), .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        rom_addr_d = rom_addr_q;
        reg_d = reg_q;
        data_d = data_q;
        nack_d = nack_q;
        retry_d = retry_q;
        load = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = FETCH;
                rom_addr_d = '0;
                nack_d = 1'b0;
            end
            FETCH: state_d = DECODE;
            DECODE: if (is_ctrl && rom_data == END_DATA) begin
                state_d = DONE;
            end else if (is_ctrl && rom_data == DELAY_DATA) begin
                load = 1'b1;
                state_d = DELAY;
            end else begin
                reg_d = rom_reg;
                data_d = rom_data;
                retry_d = '0;
                state_d = SEND;
            end
            SEND: state_d = bus.cmd_ready ? WAIT_ACK : SEND;
            // With retries disabled RETRIES is 0 and every NACK falls through to NEXT
            WAIT_ACK: if (bus.cmd_done) begin
                if (bus.cmd_nack && int'(retry_q) < RETRIES) begin
                    retry_d = retry_q + 1'b1;
                    state_d = SEND;
                end else begin
                    nack_d = nack_q | bus.cmd_nack;
                    state_d = NEXT;
                end
            end
            DELAY: state_d = expired ? NEXT : DELAY;
            NEXT: if (rom_addr_q == ROM_AW'(ROM_DEPTH - 1)) begin
                state_d = DONE;
            end else begin
                rom_addr_d = rom_addr_q + 1'b1;
                state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rom_addr_q <= '0;
            reg_q <= '0;
            data_q <= '0;
            nack_q <= 1'b0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            rom_addr_q <= rom_addr_d;
            reg_q <= reg_d;
            data_q <= data_d;
            nack_q <= nack_d;
            retry_q <= retry_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.cmd_valid = state_q == SEND;
    assign bus.cmd_reg_addr = reg_q;
    assign bus.cmd_data = data_q;
    assign busy = state_q != IDLE && state_q != DONE;
    assign done = state_q == DONE;
    assign nack_seen = nack_q;
endmodule

// File: doc/cam_config_sequencer.md
Name: cam_config_sequencer

Overview:
Walks the camera configuration ROM from address 0 and turns each entry into one SCCB/I2C register-write command for the downstream SCCB master. Decodes two in-band control entries: a fixed power-on delay and an end-of-table marker. It sits between the config ROM and the SCCB master, and reports busy/done to the top-level camera bring-up logic.

Parameters:
I2C_ADDR_16, 0, 1 = 16-bit sensor register address (OV5642, 24-bit ROM word); 0 = 8-bit (OV7670, 16-bit word)
DELAY_CYCLES, 500000, clk cycles executed for a delay entry (10 ms at 50 MHz); minimum 1
MAX_RETRY, 3, NACK retries per entry (used only with CAM_CFG_NACK_RETRY_EN)

Ports:
clk  in  1  single clock domain
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a sequence from ROM address 0
rom_addr  out  10  ROM read address
rom_dout  in  16+8*I2C_ADDR_16  ROM word, registered: valid 1 cycle after rom_addr
cmd_valid  out  1  command request to SCCB master
cmd_ready  in  1  master accepts when cmd_valid&&cmd_ready
cmd_reg_addr  out  8+8*I2C_ADDR_16  sensor register address
cmd_data  out  8  register data
cmd_done  in  1  one-cycle pulse; accepted transaction finished on the bus
cmd_nack  in  1  qualified by cmd_done; slave did not acknowledge
busy  out  1  high from the accepted start until DONE
done  out  1  level; high after the end marker until the next start or rst
nack_seen  out  1  sticky; set on any NACK in the current sequence

Behaviour:
- ROM word split: reg = upper 8+8*I2C_ADDR_16 bits; data = low 8 bits.
- END entry: reg all-ones and data 0xFF. DELAY entry: reg all-ones and data 0xF0. Any other value is a WRITE.
- Reset values: rom_addr=0, cmd_valid=0, cmd_reg_addr=0, cmd_data=0, busy=0, done=0, nack_seen=0, state=IDLE.
- IDLE: on start, go to FETCH with rom_addr=0, busy=1, done=0, nack_seen=0.
- FETCH: wait 1 cycle for ROM latency, then go to DECODE.
- DECODE: sample rom_dout. END goes to DONE. DELAY loads the counter and goes to DELAY. WRITE latches reg/data into cmd_* and goes to SEND.
- SEND: cmd_valid=1. cmd_reg_addr and cmd_data stay stable until handshake. On cmd_valid&&cmd_ready, drop cmd_valid next cycle and go to WAIT_ACK.
- WAIT_ACK: wait for cmd_done. On cmd_done with cmd_nack, set nack_seen. Then go to NEXT.
- DELAY: count DELAY_CYCLES cycles, then go to NEXT.
- NEXT: if rom_addr==1023, go to DONE (no wrap; a table without an END entry terminates after the last word). Otherwise rom_addr+1, go to FETCH.
- DONE: busy=0, done=1. A start pulse restarts as in IDLE.
- Per-entry minimum latency: WRITE takes 4 cycles plus master time; DELAY takes 3+DELAY_CYCLES.
- start while busy is ignored.
- cmd_done outside WAIT_ACK is ignored.
- rst mid-transaction aborts immediately: all outputs return to reset values and cmd_valid drops the same cycle rst is sampled. The master is reset by the same rst.

Optional Feature:
CAM_CFG_NACK_RETRY_EN.
- Defined: on NACK, re-enter SEND with the same entry, up to MAX_RETRY times. nack_seen is set only if the final attempt still NACKs; the sequencer then advances.
- Undefined: no retry; a NACK sets nack_seen and the sequencer advances. MAX_RETRY is unused.

Decomposition:
- Package cam_cfg_pkg: END_DATA=8'hFF, DELAY_DATA=8'hF0, ROM_DEPTH=1024, state encoding (IDLE, FETCH, DECODE, SEND, WAIT_ACK, DELAY, NEXT, DONE).
- Sub-module cam_cfg_delay_timer (load/count/expire, width $clog2(DELAY_CYCLES+1)).

Test Plan:
- 8-bit mode, ROM {0x1280, 0x1101, 0xFFFF}, master ready=1, cmd_done 2 cycles after accept -> exactly two commands (0x12/0x80, 0x11/0x01), then done=1, busy=0, rom_addr=2.
- ROM {0xFFF0, 0x3A04, 0xFFFF}, DELAY_CYCLES=20 -> first cmd_valid rises no earlier than 23 cycles after start; one command issued.
- cmd_ready held low 50 cycles in SEND -> cmd_valid stays high and cmd_* stay stable for the full 50 cycles; exactly one accept.
- Second command NACKed -> without the macro: nack_seen=1 and 3 total commands issued. With the macro and MAX_RETRY=3, NACKing every attempt: the entry is sent 4 times, then nack_seen=1.
- rst asserted while in WAIT_ACK, then start -> all outputs at reset values the cycle after rst; the sequence reissues from address 0.
- I2C_ADDR_16=1, ROM {24'h300812, 24'hFFFFFF} -> one command with reg 0x3008 and data 0x12, then done; a ROM with no END entry finishes at rom_addr=1023 with done=1.
